mult_shift_stage: RTL and testbench

MULT_SHIFT_STAGE -- requirements
Module: mult_shift_stage

---
 rtl/mult_shift_stage_pkg.sv | 11 +
 rtl/mss_barrel_shifter.sv | 26 ++
 rtl/mult_shift_stage.sv | 89 ++++++++
 tb/tb_mult_shift_stage.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mult_shift_stage_pkg.sv
// Shared widths and shift-direction encoding for the multiply shift-and-add stage.
package mult_shift_stage_pkg;

  localparam int OPW = 32;
  localparam int PPW = 64;
  localparam int CTW = 5;

  localparam logic SH_LEFT  = 1'b0;
  localparam logic SH_RIGHT = 1'b1;

endpackage

// File: rtl/mss_barrel_shifter.sv
// Five-stage logarithmic barrel shifter with zero fill; dir selects left or logical right.
module mss_barrel_shifter
  import mult_shift_stage_pkg::*;
#(
  parameter int WIDTH = OPW
) (
  input  logic [CTW-1:0]   count,
  input  logic             dir,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] w_stage [0:CTW];

  assign w_stage[0] = data;

  for (genvar s = 0; s < CTW; s++) begin : g_stage
    localparam int SH = 1 << s;
    assign w_stage[s+1] = !count[s]        ? w_stage[s] :
                          (dir == SH_LEFT) ? (w_stage[s] << SH) :
                                             (w_stage[s] >> SH);
  end

  assign result = w_stage[CTW];

endmodule

// File: rtl/mult_shift_stage.sv
// One step of a shift-and-add multiplier: shifted multiplicand, shifted multiplier, masked addend.
// Optional MSS_ZERO_DETECT_EN adds a registered done flag when the shifted multiplier is zero.
module mult_shift_stage
  import mult_shift_stage_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  input  logic [CTW-1:0] ct,
  input  logic [OPW-1:0] a_in,
  input  logic [OPW-1:0] b_in,
  output logic [PPW-1:0] a_sh,
  output logic [OPW-1:0] b_sh,
  output logic [PPW-1:0] addend,
  output logic           out_valid
`ifdef MSS_ZERO_DETECT_EN
  ,
  output logic           done
`endif
);

  logic [PPW-1:0] w_a_ext;
  logic [PPW-1:0] w_a_sh;
  logic [OPW-1:0] w_b_sh;
  logic [PPW-1:0] w_addend;

  logic           r_vld_p1;
  logic [PPW-1:0] r_a_sh_p1;
  logic [OPW-1:0] r_b_sh_p1;
  logic [PPW-1:0] r_addend_p1;

  assign w_a_ext = {{(PPW-OPW){1'b0}}, a_in};

  mss_barrel_shifter #(.WIDTH(PPW)) u_shl (
    .count  (ct),
    .dir    (SH_LEFT),
    .data   (w_a_ext),
    .result (w_a_sh)
  );

  mss_barrel_shifter #(.WIDTH(OPW)) u_shr (
    .count  (ct),
    .dir    (SH_RIGHT),
    .data   (b_in),
    .result (w_b_sh)
  );

  assign w_addend = w_a_sh & {PPW{w_b_sh[0]}};

  // p0 -> p1: single output register stage; data holds when in_valid is low
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_p1    <= 1'b0;
      r_a_sh_p1   <= '0;
      r_b_sh_p1   <= '0;
      r_addend_p1 <= '0;
    end else begin
      r_vld_p1 <= in_valid;
      if (in_valid) begin
        r_a_sh_p1   <= w_a_sh;
        r_b_sh_p1   <= w_b_sh;
        r_addend_p1 <= w_addend;
      end
    end
  end

  assign a_sh      = r_a_sh_p1;
  assign b_sh      = r_b_sh_p1;
  assign addend    = r_addend_p1;
  assign out_valid = r_vld_p1;

`ifdef MSS_ZERO_DETECT_EN
  logic w_done;
  logic r_done_p1;

  assign w_done = ~|w_b_sh;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_done_p1 <= 1'b0;
    end else if (in_valid) begin
      r_done_p1 <= w_done;
    end
  end

  assign done = r_done_p1;
`endif

endmodule

// File: tb/tb_mult_shift_stage.sv
// Scoreboard bench for mult_shift_stage: directed vectors, random vectors, pipeline/hold and reset priority.
module tb_mult_shift_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [4:0]  ct;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [63:0] a_sh;
  logic [31:0] b_sh;
  logic [63:0] addend;
  logic        out_valid;
`ifdef MSS_ZERO_DETECT_EN
  logic        done;
`endif

  always #5 clk = ~clk;

  mult_shift_stage dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .ct        (ct),
    .a_in      (a_in),
    .b_in      (b_in),
    .a_sh      (a_sh),
    .b_sh      (b_sh),
    .addend    (addend),
    .out_valid (out_valid)
`ifdef MSS_ZERO_DETECT_EN
    ,
    .done      (done)
`endif
  );

  typedef struct packed {
    logic [63:0] a_sh;
    logic [31:0] b_sh;
    logic [63:0] addend;
    logic        done;
  } exp_t;

  typedef struct packed {
    logic [4:0]  ct;
    logic [31:0] a;
    logic [31:0] b;
    exp_t        e;
  } vec_t;

  exp_t sb[$];
  exp_t last_exp;
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic exp_t model(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.a_sh   = {32'd0, a} << c;
    e.b_sh   = b >> c;
    e.addend = e.b_sh[0] ? e.a_sh : 64'd0;
    e.done   = (e.b_sh == 32'd0);
    return e;
  endfunction

  task automatic drive(input logic v, input logic [4:0] c, input logic [31:0] a,
                       input logic [31:0] b, input exp_t e);
    in_valid = v;
    ct       = c;
    a_in     = a;
    b_in     = b;
    if (v && !reset) sb.push_back(e);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, 5'd3, 32'hDEADBEEF, 32'h0000000F, '0);
    @(posedge clk); #1;
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_tests++;
    if (a_sh !== 64'd0) begin n_fail++; $display("FAIL reset_a_sh got %h want 0", a_sh); end
    n_tests++;
    if (b_sh !== 32'd0) begin n_fail++; $display("FAIL reset_b_sh got %h want 0", b_sh); end
    n_tests++;
    if (addend !== 64'd0) begin n_fail++; $display("FAIL reset_addend got %h want 0", addend); end
`ifdef MSS_ZERO_DETECT_EN
    n_tests++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
`endif
    reset = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 32'd0, '0);
  endtask

  task automatic test_vectors();
    vec_t vecs[$];
    vec_t v;
    exp_t e;
    vecs.push_back('{5'd0,  32'h00000001, 32'h00000001,
                     '{64'h1, 32'h1, 64'h1, 1'b0}});
    vecs.push_back('{5'd31, 32'hFFFFFFFF, 32'h80000000,
                     '{64'h7FFFFFFF80000000, 32'h1, 64'h7FFFFFFF80000000, 1'b0}});
    vecs.push_back('{5'd4,  32'h12345678, 32'h000000E0,
                     '{64'h0000000123456780, 32'hE, 64'h0, 1'b0}});
    vecs.push_back('{5'd5,  32'hAAAAAAAA, 32'h0000001F,
                     '{64'h0000001555555540, 32'h0, 64'h0, 1'b1}});
    vecs.push_back('{5'd0,  32'hCAFEF00D, 32'h89ABCDEF,
                     '{64'h00000000CAFEF00D, 32'h89ABCDEF, 64'h00000000CAFEF00D, 1'b0}});
    for (int i = 0; i < 16; i++) begin
      v.ct = 5'($urandom_range(0, 31));
      v.a  = $urandom;
      v.b  = $urandom | (32'h1 << v.ct);
      if (i % 4 == 3) v.b = v.b & ~(32'h1 << v.ct);
      v.e  = model(v.ct, v.a, v.b);
      vecs.push_back(v);
    end
    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].ct, vecs[i].a, vecs[i].b, vecs[i].e);
      @(posedge clk); #1;
      n_tests++;
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL vec%0d_out_valid got %b want 1", i, out_valid); end
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++; $display("FAIL vec%0d_scoreboard empty got 0 entries want 1", i);
      end else begin
        e = sb.pop_front();
        last_exp = e;
        if (a_sh !== e.a_sh) begin n_fail++; $display("FAIL vec%0d_a_sh got %h want %h", i, a_sh, e.a_sh); end
        n_tests++;
        if (b_sh !== e.b_sh) begin n_fail++; $display("FAIL vec%0d_b_sh got %h want %h", i, b_sh, e.b_sh); end
        n_tests++;
        if (addend !== e.addend) begin n_fail++; $display("FAIL vec%0d_addend got %h want %h", i, addend, e.addend); end
`ifdef MSS_ZERO_DETECT_EN
        n_tests++;
        if (done !== e.done) begin n_fail++; $display("FAIL vec%0d_done got %b want %b", i, done, e.done); end
`endif
      end
    end
    drive(1'b0, 5'd0, 32'd0, 32'd0, '0);
  endtask

  task automatic test_pipeline_hold();
    logic [4:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    logic        v;
    exp_t        e;
    for (int i = 0; i < 6; i++) begin
      v = (i < 3);
      c = 5'(i * 7 + 2);
      a = 32'h13579BDF + 32'(i) * 32'h01010101;
      b = 32'hF0F0F0F5 >> i;
      drive(v, c, a, b, model(c, a, b));
      @(posedge clk); #1;
      n_tests++;
      if (out_valid !== v) begin n_fail++; $display("FAIL pipe%0d_out_valid got %b want %b", i, out_valid, v); end
      if (v) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL pipe%0d_scoreboard empty got 0 entries want 1", i);
        end else begin
          e = sb.pop_front();
          last_exp = e;
        end
      end
      e = last_exp;
      n_tests++;
      if (a_sh !== e.a_sh) begin n_fail++; $display("FAIL pipe%0d_a_sh got %h want %h", i, a_sh, e.a_sh); end
      n_tests++;
      if (b_sh !== e.b_sh) begin n_fail++; $display("FAIL pipe%0d_b_sh got %h want %h", i, b_sh, e.b_sh); end
      n_tests++;
      if (addend !== e.addend) begin n_fail++; $display("FAIL pipe%0d_addend got %h want %h", i, addend, e.addend); end
`ifdef MSS_ZERO_DETECT_EN
      n_tests++;
      if (done !== e.done) begin n_fail++; $display("FAIL pipe%0d_done got %b want %b", i, done, e.done); end
`endif
    end
  endtask

  task automatic test_reset_priority();
    exp_t e;
    drive(1'b1, 5'd31, 32'hFFFFFFFF, 32'h80000000, model(5'd31, 32'hFFFFFFFF, 32'h80000000));
    @(posedge clk); #1;
    e = sb.pop_front();
    n_tests++;
    if (addend !== e.addend) begin n_fail++; $display("FAIL rstpri_pre_addend got %h want %h", addend, e.addend); end
    reset = 1'b1;
    drive(1'b1, 5'd1, 32'h55555555, 32'h00000003, '0);
    @(posedge clk); #1;
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstpri_out_valid got %b want 0", out_valid); end
    n_tests++;
    if ({a_sh, b_sh, addend} !== 160'd0) begin
      n_fail++; $display("FAIL rstpri_data got %h/%h/%h want 0/0/0", a_sh, b_sh, addend);
    end
`ifdef MSS_ZERO_DETECT_EN
    n_tests++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL rstpri_done got %b want 0", done); end
`endif
    reset = 1'b0;
    drive(1'b1, 5'd8, 32'h0000ABCD, 32'h00000300, model(5'd8, 32'h0000ABCD, 32'h00000300));
    @(posedge clk); #1;
    n_tests++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL postrst_out_valid got %b want 1", out_valid); end
    e = sb.pop_front();
    n_tests++;
    if (addend !== e.addend) begin n_fail++; $display("FAIL postrst_addend got %h want %h", addend, e.addend); end
    n_tests++;
    if (b_sh !== e.b_sh) begin n_fail++; $display("FAIL postrst_b_sh got %h want %h", b_sh, e.b_sh); end
    drive(1'b0, 5'd0, 32'd0, 32'd0, '0);
    @(posedge clk); #1;
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL postrst_idle_out_valid got %b want 0", out_valid); end
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    ct       = '0;
    a_in     = '0;
    b_in     = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_vectors();
    test_pipeline_hold();
    test_reset_priority();
    n_tests++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain got %0d entries want 0", sb.size()); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
